// File: rtl/true_count_calc.sv
// true_count_calc: cards remaining and true count (running count per remaining
// deck) in signed fixed point. A multi-cycle restoring divider avoids a
// combinational divide; busy/valid report progress to the display stage.
module true_count_calc #(
   parameter int unsigned CARDS_PER_DECK = 52,
   parameter int unsigned FRAC_BITS      = 4,
   parameter int unsigned NUM_W          = 26
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [7:0]         deck,
   input  logic [15:0]        total,
   input  logic signed [15:0] offset,
   output logic [15:0]        remaining,
   output logic signed [15:0] true_count,
   output logic               valid,
   output logic               busy,
   output logic               div_zero
);

   localparam int unsigned CNT_W = $clog2(NUM_W);
   localparam logic [16:0] CPD = 17'(CARDS_PER_DECK);
   localparam logic [NUM_W-1:0] SCALE = NUM_W'(CARDS_PER_DECK * (2 ** FRAC_BITS));
   localparam logic [NUM_W-1:0] Q_MAX = NUM_W'(32767);

   typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

   state_t             state_q, state_d;
   logic [7:0]         deck_q, deck_d;
   logic [15:0]        total_q, total_d;
   logic [15:0]        offset_q, offset_d;
   logic               force_q, force_d;
   logic [NUM_W-1:0]   num_q, num_d;
   logic [16:0]        prem_q, prem_d;
   logic [15:0]        rem_div_q, rem_div_d;
   logic               sign_q, sign_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [15:0]        remaining_q, remaining_d;
   logic [15:0]        true_count_q, true_count_d;
   logic               valid_q, valid_d;
   logic               busy_q, busy_d;
   logic               div_zero_q, div_zero_d;

   logic [16:0]        shoe;
   logic [15:0]        rem_calc;
   logic [15:0]        mag;
   logic [NUM_W-1:0]   num_load;
   logic [17:0]        trial;
   logic [17:0]        diff;
   logic               take;
   logic               changed;
   logic [15:0]        q16;

   // Divider operand preparation from the live inputs (used on the capture edge)
   always_comb begin
      shoe     = 17'(deck) * CPD;
      rem_calc = ({1'b0, total} >= shoe) ? 16'd0 : 16'(shoe - {1'b0, total});
      mag      = offset[15] ? (~offset + 16'd1) : offset;
      num_load = NUM_W'(mag) * SCALE;
      changed  = ({deck, total, offset} != {deck_q, total_q, offset_q});
      trial    = {prem_q, num_q[NUM_W-1]};
      diff     = trial - {2'b00, rem_div_q};
      take     = (trial >= {2'b00, rem_div_q});
      q16      = num_q[15:0];
   end

   // Next-state and datapath control
   always_comb begin
      state_d      = state_q;
      deck_d       = deck_q;
      total_d      = total_q;
      offset_d     = offset_q;
      force_d      = force_q;
      num_d        = num_q;
      prem_d       = prem_q;
      rem_div_d    = rem_div_q;
      sign_d       = sign_q;
      cnt_d        = cnt_q;
      remaining_d  = remaining_q;
      true_count_d = true_count_q;
      valid_d      = valid_q;
      busy_d       = busy_q;
      div_zero_d   = div_zero_q;

      case (state_q)
         IDLE: begin
            if (force_q || changed) begin
               deck_d    = deck;
               total_d   = total;
               offset_d  = offset;
               force_d   = 1'b0;
               busy_d    = 1'b1;
               valid_d   = 1'b0;
               num_d     = num_load;
               prem_d    = 17'd0;
               rem_div_d = rem_calc;
               sign_d    = offset[15];
               cnt_d     = CNT_W'(NUM_W - 1);
               state_d   = DIV;
            end
         end
         DIV: begin
            // One restoring step: the dividend shifts out as the quotient shifts in
            prem_d = take ? 17'(diff) : 17'(trial);
            num_d  = {num_q[NUM_W-2:0], take};
            if (cnt_q == '0) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DONE: begin
            remaining_d = rem_div_q;
            if (rem_div_q == 16'd0) begin
               true_count_d = 16'd0;
               div_zero_d   = 1'b1;
            end else begin
               div_zero_d = 1'b0;
               if (num_q > Q_MAX) begin
                  true_count_d = sign_q ? 16'h8001 : 16'h7fff;
               end else begin
                  true_count_d = sign_q ? (~q16 + 16'd1) : q16;
               end
            end
            valid_d = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         deck_q       <= '0;
         total_q      <= '0;
         offset_q     <= '0;
         force_q      <= 1'b1;
         num_q        <= '0;
         prem_q       <= '0;
         rem_div_q    <= '0;
         sign_q       <= 1'b0;
         cnt_q        <= '0;
         remaining_q  <= '0;
         true_count_q <= '0;
         valid_q      <= 1'b0;
         busy_q       <= 1'b0;
         div_zero_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         deck_q       <= deck_d;
         total_q      <= total_d;
         offset_q     <= offset_d;
         force_q      <= force_d;
         num_q        <= num_d;
         prem_q       <= prem_d;
         rem_div_q    <= rem_div_d;
         sign_q       <= sign_d;
         cnt_q        <= cnt_d;
         remaining_q  <= remaining_d;
         true_count_q <= true_count_d;
         valid_q      <= valid_d;
         busy_q       <= busy_d;
         div_zero_q   <= div_zero_d;
      end
   end

   assign remaining  = remaining_q;
   assign true_count = true_count_q;
   assign valid      = valid_q;
   assign busy       = busy_q;
   assign div_zero   = div_zero_q;

endmodule

// File: tb/tb_true_count_calc.sv
// Directed bench for true_count_calc: expected results are queued when a
// snapshot is driven and popped when valid rises.
module tb_true_count_calc;

   logic               clk;
   logic               rst;
   logic [7:0]         deck;
   logic [15:0]        total;
   logic signed [15:0] offset;
   logic [15:0]        remaining;
   logic signed [15:0] true_count;
   logic               valid;
   logic               busy;
   logic               div_zero;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] rem;
      logic [15:0] tc;
      logic        dz;
   } exp_t;

   exp_t sb[$];

   true_count_calc dut (
      .clk        (clk),
      .rst        (rst),
      .deck       (deck),
      .total      (total),
      .offset     (offset),
      .remaining  (remaining),
      .true_count (true_count),
      .valid      (valid),
      .busy       (busy),
      .div_zero   (div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   function automatic exp_t mk(input int r, input int tc, input bit dz);
      exp_t e;
      e.rem = 16'(r);
      e.tc  = 16'(tc);
      e.dz  = dz;
      return e;
   endfunction

   // Reference: remaining cards, then |offset|*52*16 / remaining, truncated, saturated
   function automatic exp_t model(input int d, input int t, input int o);
      int shoe;
      int r;
      longint m;
      longint q;
      shoe = d * 52;
      r    = (t >= shoe) ? 0 : shoe - t;
      if (r == 0) return mk(0, 0, 1'b1);
      m = (o < 0) ? -o : o;
      q = (m * 832) / r;
      if (q > 32767) q = 32767;
      return mk(r, (o < 0) ? -int'(q) : int'(q), 1'b0);
   endfunction

   // Wait (bounded) for valid; n = edges after the capture edge
   task automatic wait_valid(output int n);
      n = 0;
      while (valid !== 1'b1 && n < 60) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic pop_compare(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s_sb observed=empty expected=entry", tag);
      end else begin
         e = sb.pop_front();
         check({tag, "_valid"}, 32'(valid), 32'(1));
         check({tag, "_busy"}, 32'(busy), 32'(0));
         check({tag, "_rem"}, 32'(remaining), 32'(e.rem));
         check({tag, "_tc"}, 32'($signed(true_count)), 32'($signed(e.tc)));
         check({tag, "_dz"}, 32'(div_zero), 32'(e.dz));
      end
   endtask

   task automatic run_case(input string tag, input int d, input int t, input int o, input exp_t e);
      int n;
      deck   = 8'(d);
      total  = 16'(t);
      offset = 16'(o);
      sb.push_back(e);
      @(posedge clk);
      #1;
      check({tag, "_start_busy"}, 32'(busy), 32'(1));
      check({tag, "_start_valid"}, 32'(valid), 32'(0));
      wait_valid(n);
      check({tag, "_latency"}, 32'(n), 32'(27));
      pop_compare(tag);
   endtask

   initial begin
      int n;
      int rd;
      int rt;
      int ro;
      rst    = 1'b1;
      deck   = 8'd1;
      total  = 16'd0;
      offset = 16'sd0;

      // Reset values
      @(posedge clk);
      #1;
      check("rst_rem", 32'(remaining), 32'(0));
      check("rst_tc", 32'($signed(true_count)), 32'(0));
      check("rst_valid", 32'(valid), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_dz", 32'(div_zero), 32'(0));

      // Forced computation after reset with all-zero running count
      sb.push_back(mk(52, 0, 1'b0));
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("force_busy", 32'(busy), 32'(1));
      wait_valid(n);
      check("force_latency", 32'(n), 32'(27));
      pop_compare("force");

      run_case("plus4", 2, 52, 4, mk(52, 64, 1'b0));
      run_case("minus3", 1, 26, -3, mk(26, -96, 1'b0));
      run_case("zero_rem", 0, 0, 0, mk(0, 0, 1'b1));
      run_case("sat_pos", 1, 51, 1000, mk(1, 32767, 1'b0));
      run_case("sat_neg", 1, 51, -32768, mk(1, -32767, 1'b0));
      run_case("over_dealt", 1, 60, 7, mk(0, 0, 1'b1));

      // Hold: unchanged inputs keep the result and start no pass
      repeat (5) @(posedge clk);
      #1;
      check("hold_valid", 32'(valid), 32'(1));
      check("hold_busy", 32'(busy), 32'(0));

      // Input change in the middle of a pass
      deck   = 8'd2;
      total  = 16'd52;
      offset = 16'sd4;
      sb.push_back(mk(52, 64, 1'b0));
      @(posedge clk);
      #1;
      check("mid_start_busy", 32'(busy), 32'(1));
      repeat (10) @(posedge clk);
      #1;
      offset = 16'sd5;
      sb.push_back(mk(52, 80, 1'b0));
      wait_valid(n);
      check("mid_first_latency", 32'(n), 32'(17));
      pop_compare("mid_first");
      @(posedge clk);
      #1;
      check("mid_second_busy", 32'(busy), 32'(1));
      check("mid_second_valid", 32'(valid), 32'(0));
      wait_valid(n);
      check("mid_second_latency", 32'(n), 32'(27));
      pop_compare("mid_second");

      // Asynchronous reset in the middle of a pass
      deck   = 8'd1;
      total  = 16'd0;
      offset = 16'sd8;
      sb.push_back(mk(52, 128, 1'b0));
      @(posedge clk);
      #1;
      check("arst_start_busy", 32'(busy), 32'(1));
      repeat (5) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("arst_rem", 32'(remaining), 32'(0));
      check("arst_tc", 32'($signed(true_count)), 32'(0));
      check("arst_valid", 32'(valid), 32'(0));
      check("arst_busy", 32'(busy), 32'(0));
      check("arst_dz", 32'(div_zero), 32'(0));
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("arst_restart_busy", 32'(busy), 32'(1));
      wait_valid(n);
      check("arst_latency", 32'(n), 32'(27));
      pop_compare("arst");

      // Pseudo-random snapshots against the reference model
      for (int i = 0; i < 6; i++) begin
         rd = int'($urandom_range(1, 8));
         rt = int'($urandom_range(0, 52 * rd + 4));
         ro = int'($urandom_range(0, 400)) - 200;
         if (rd == int'(deck) && rt == int'(total) && ro == int'(offset)) ro = ro + 1;
         run_case("rand", rd, rt, ro, model(rd, rt, ro));
      end

      check("sb_empty", 32'(sb.size()), 32'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
